vhd_serial_sector_controller: RTL and testbench

- Memory-mapped virtual-disk controller: CPU-side register/buffer port plus RS-232 link to a host that stores disk sectors.
- Holds a 512-byte sector buffer, a 32-bit disk offset, a command register and a ready flag.
- On command, sends a 5-byte header over UART. It then either receives 512 bytes into the buffer (read sector) or transmits the buffer (write sector).
- Integrates its own 8N1 UART transmitter and receiver and a 512x8 buffer RAM.

---
 rtl/vhd_serial_sector_controller.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_vhd_serial_sector_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vhd_serial_sector_controller.sv
// Virtual-disk controller: CPU register/buffer port plus an 8N1 UART link to a
// host that stores 512-byte sectors.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   rxd / txd         : UART receive / transmit lines (idle high)
//   addr[8:0]         : bit8=1 buffer (halfword index), bit8=0 register select
//   chip_select       : request strobe, held until mem_ok
//   write_data[31:0]  : store data; save_half selects a 16-bit store
//   load_half         : 16-bit sign-extended load
//   mem_write/mem_read: store (has priority) / load request
//   mem_read_data     : registered load result
//   mem_ok            : one-cycle completion pulse
module vhd_serial_sector_controller #(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned BUFFER_SIZE = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic        txd,
  input  logic [8:0]  addr,
  input  logic        chip_select,
  input  logic [31:0] write_data,
  input  logic        save_half,
  input  logic        load_half,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] mem_read_data,
  output logic        mem_ok
);

  localparam int unsigned BIT_CLKS = CLK_FREQ / BAUD;
  localparam logic [15:0] BIT_M1   = 16'(BIT_CLKS - 1);
  localparam logic [15:0] HALF_M1  = 16'(BIT_CLKS / 2 - 1);
  localparam logic [9:0]  BUF_END  = 10'(BUFFER_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_RECOVER, S_HDR, S_RX, S_TXD} state_t;
  state_t r_state, w_state_next;

  logic [31:0] r_offset, r_rdata, r_wdata;
  logic [15:0] r_command;
  logic        r_ready, r_mem_ok, r_wr, r_half, r_dir;
  logic [8:0]  r_addr;
  logic [2:0]  r_step, r_nbytes, r_hidx;
  logic [9:0]  r_ptr;

  logic [7:0]  r_mem [BUFFER_SIZE];
  logic [7:0]  r_ram_q, w_ram_wd;
  logic [8:0]  w_ram_addr;
  logic        w_ram_we;

  logic        r_tx_busy, r_txd, w_tx_start;
  logic [8:0]  r_tx_sh;
  logic [15:0] r_tx_cnt;
  logic [3:0]  r_tx_bits;
  logic [7:0]  w_tx_byte;

  logic        r_rx_s1, r_rx_s2, r_rx_s3, r_rx_busy, r_rx_valid;
  logic [15:0] r_rx_cnt;
  logic [3:0]  r_rx_bit;
  logic [7:0]  r_rx_sh, r_rx_data;

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
    case (l)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // Each access step touches one byte; RAM data returns one step later, so
  // n bytes complete on step n+1 (registers use n=0).
  logic       w_cmd_go, w_buf_op, w_capture, w_access_done;
  logic [8:0] w_byte_addr;
  logic [1:0] w_wr_lane, w_cap_lane;

  assign w_cmd_go      = (r_command == 16'd1 || r_command == 16'd2) && !r_tx_busy;
  assign w_byte_addr   = {r_addr[7:0], 1'b0} + {6'b0, r_step};
  assign w_wr_lane     = r_half ? r_step[1:0] + 2'd2 : r_step[1:0];
  assign w_cap_lane    = r_half ? r_step[1:0] + 2'd1 : r_step[1:0] - 2'd1;
  assign w_buf_op      = r_addr[8] && (r_step < r_nbytes);
  assign w_capture     = r_addr[8] && !r_wr && (r_step != 3'd0) && (r_step <= r_nbytes);
  assign w_access_done = (r_step == r_nbytes + 3'd1);

  always_comb begin
    w_state_next = r_state;
    w_ram_addr   = r_ptr[8:0];
    w_ram_we     = 1'b0;
    w_ram_wd     = r_rx_data;
    w_tx_start   = 1'b0;
    w_tx_byte    = r_ram_q;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_go)         w_state_next = S_HDR;
        else if (chip_select) w_state_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (w_buf_op) begin
          w_ram_addr = w_byte_addr;
          w_ram_we   = r_wr;
          w_ram_wd   = lane_byte(r_wdata, w_wr_lane);
        end
        if (w_access_done) w_state_next = S_RECOVER;
      end
      S_RECOVER: w_state_next = S_IDLE;
      S_HDR: begin
        w_tx_byte = (r_hidx == 3'd4) ? r_command[7:0] : lane_byte(r_offset, r_hidx[1:0]);
        if (!r_tx_busy) begin
          w_tx_start = 1'b1;
          if (r_hidx == 3'd4) w_state_next = r_dir ? S_RX : S_TXD;
        end
      end
      S_RX: begin
        if (r_ptr == BUF_END) w_state_next = S_IDLE;
        else if (r_rx_valid)  w_ram_we = 1'b1;
      end
      S_TXD: begin
        // RAM output already holds buffer[r_ptr]: the pointer only moves at a
        // frame start and the frame lasts far longer than the read latency.
        if (!r_tx_busy) begin
          if (r_ptr == BUF_END) w_state_next = S_IDLE;
          else                  w_tx_start = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_offset  <= 32'h12345678;
      r_command <= '0;
      r_ready   <= 1'b1;
      r_mem_ok  <= 1'b0;
      r_rdata   <= '0;
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_half    <= 1'b0;
      r_wdata   <= '0;
      r_step    <= '0;
      r_nbytes  <= '0;
      r_ptr     <= '0;
      r_hidx    <= '0;
      r_dir     <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_mem_ok <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_go) begin
            r_ready <= 1'b0;
            r_ptr   <= '0;
            r_hidx  <= '0;
            r_dir   <= (r_command == 16'd1);
          end else if (chip_select) begin
            r_addr  <= addr;
            r_wr    <= mem_write;
            r_half  <= mem_write ? save_half : (mem_read & load_half);
            r_wdata <= write_data;
            r_rdata <= '0;
            r_step  <= '0;
            if (!addr[8])                                            r_nbytes <= 3'd0;
            else if (mem_write ? save_half : (mem_read & load_half)) r_nbytes <= 3'd2;
            else if (addr[7:0] == 8'hFF)                             r_nbytes <= 3'd2;
            else                                                     r_nbytes <= 3'd4;
          end
        end
        S_ACCESS: begin
          r_step <= r_step + 3'd1;
          if (!r_addr[8] && r_step == 3'd0) begin
            if (r_wr) begin
              if (r_addr[7:0] == 8'hFC) r_offset  <= r_wdata;
              if (r_addr[7:0] == 8'hFE) r_command <= r_wdata[15:0];
            end else begin
              case (r_addr[7:0])
                8'hFC:   r_rdata <= r_offset;
                8'hFE:   r_rdata <= {16'h0, r_command};
                8'hFF:   r_rdata <= {31'h0, r_ready};
                default: r_rdata <= '0;
              endcase
            end
          end
          if (w_capture) begin
            case (w_cap_lane)
              2'd0:    r_rdata[31:24] <= r_ram_q;
              2'd1:    r_rdata[23:16] <= r_ram_q;
              2'd2:    r_rdata[15:8]  <= r_ram_q;
              default: r_rdata[7:0]   <= r_ram_q;
            endcase
            if (r_half && r_step == 3'd1) r_rdata[31:16] <= {16{r_ram_q[7]}};
          end
          if (w_access_done) r_mem_ok <= 1'b1;
        end
        S_RECOVER: if (r_command != 16'd0) r_ready <= 1'b0;
        S_HDR: begin
          if (!r_tx_busy) begin
            r_hidx <= r_hidx + 3'd1;
            if (r_hidx == 3'd4) r_command <= '0;
          end
        end
        S_RX: begin
          if (r_ptr == BUF_END) r_ready <= 1'b1;
          else if (r_rx_valid)  r_ptr <= r_ptr + 10'd1;
        end
        S_TXD: begin
          if (!r_tx_busy) begin
            if (r_ptr == BUF_END) r_ready <= 1'b1;
            else                  r_ptr <= r_ptr + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wd;
    r_ram_q <= r_mem[w_ram_addr];
  end

  // Transmitter: start bit goes out on the start edge; r_tx_sh holds the
  // remaining data bits with the stop bit as the top entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_busy <= 1'b0;
      r_txd     <= 1'b1;
      r_tx_sh   <= '1;
      r_tx_cnt  <= '0;
      r_tx_bits <= '0;
    end else if (w_tx_start) begin
      r_tx_busy <= 1'b1;
      r_txd     <= 1'b0;
      r_tx_sh   <= {1'b1, w_tx_byte};
      r_tx_cnt  <= '0;
      r_tx_bits <= '0;
    end else if (r_tx_busy) begin
      if (r_tx_cnt == BIT_M1) begin
        r_tx_cnt <= '0;
        if (r_tx_bits == 4'd9) begin
          r_tx_busy <= 1'b0;
        end else begin
          r_txd     <= r_tx_sh[0];
          r_tx_sh   <= {1'b1, r_tx_sh[8:1]};
          r_tx_bits <= r_tx_bits + 4'd1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + 16'd1;
      end
    end
  end

  // Receiver: r_rx_bit 0 = start confirm at half bit, 1..8 data, 9 stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_busy  <= 1'b0;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      r_rx_s1    <= rxd;
      r_rx_s2    <= r_rx_s1;
      r_rx_s3    <= r_rx_s2;
      r_rx_valid <= 1'b0;
      if (!r_rx_busy) begin
        if (r_rx_s3 && !r_rx_s2) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt  <= '0;
          r_rx_bit  <= '0;
        end
      end else if (r_rx_cnt == ((r_rx_bit == 4'd0) ? HALF_M1 : BIT_M1)) begin
        r_rx_cnt <= '0;
        if (r_rx_bit == 4'd0) begin
          if (r_rx_s2) r_rx_busy <= 1'b0;
          else         r_rx_bit  <= 4'd1;
        end else if (r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          if (r_rx_s2) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= r_rx_sh;
          end
        end else begin
          r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 4'd1;
        end
      end else begin
        r_rx_cnt <= r_rx_cnt + 16'd1;
      end
    end
  end

  assign txd           = r_txd;
  assign mem_read_data = r_rdata;
  assign mem_ok        = r_mem_ok;

endmodule

// File: tb/tb_vhd_serial_sector_controller.sv
// Directed bench for vhd_serial_sector_controller with a 4-clock UART bit.
module tb_vhd_serial_sector_controller;

  logic        clk = 1'b0;
  logic        rst, rxd, txd;
  logic [8:0]  addr;
  logic        chip_select, save_half, load_half, mem_write, mem_read, mem_ok;
  logic [31:0] write_data, mem_read_data;

  int n_assert = 0;
  int n_fail   = 0;
  int ok_cnt   = 0;

  always #5 clk = ~clk;

  vhd_serial_sector_controller #(.CLK_FREQ(400000), .BAUD(100000), .BUFFER_SIZE(512)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd), .addr(addr),
    .chip_select(chip_select), .write_data(write_data), .save_half(save_half),
    .load_half(load_half), .mem_write(mem_write), .mem_read(mem_read),
    .mem_read_data(mem_read_data), .mem_ok(mem_ok)
  );

  always @(negedge clk) if (mem_ok === 1'b1) ok_cnt <= ok_cnt + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_req(input logic we, input logic half, input logic [8:0] a, input logic [31:0] wd);
    @(negedge clk);
    chip_select = 1'b1; mem_write = we; mem_read = !we;
    save_half = half & we; load_half = half & !we;
    addr = a; write_data = wd;
  endtask

  task automatic bus_done(input int maxc, output logic [31:0] rd, output int lat);
    logic seen;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < maxc) begin
      @(negedge clk);
      lat++;
      seen = (mem_ok === 1'b1);
    end
    rd = mem_read_data;
    chip_select = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    save_half = 1'b0; load_half = 1'b0;
    chk("ok_seen", {31'b0, seen}, 32'd1);
    @(negedge clk);
    chk("ok_width", {31'b0, mem_ok}, 32'd0);
  endtask

  task automatic acc(input logic we, input logic half, input logic [8:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output int lat);
    bus_req(we, half, a, wd);
    bus_done(400, rd, lat);
  endtask

  task automatic recv_frame(output logic [7:0] b, output logic ok);
    int w;
    logic st, sp;
    w = 0; b = '0;
    while (txd !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (txd !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    @(negedge clk);
    st = txd;
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = txd;
    end
    repeat (4) @(negedge clk);
    sp = txd;
    ok = (st === 1'b0) && (sp === 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (4) @(negedge clk);
    end
    rxd = stop;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    if (!stop) repeat (8) @(negedge clk);
  endtask

  logic [31:0] rd, rd2;
  int          lat, lat2, ok0, lows;
  logic [7:0]  fb, ex;
  logic        fok;
  logic [39:0] hdr;

  initial begin
    rst = 1'b1; rxd = 1'b1; addr = '0; chip_select = 1'b0; write_data = '0;
    save_half = 1'b0; load_half = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("txd_rst", {31'b0, txd}, 32'd1);
    chk("ok_rst", {31'b0, mem_ok}, 32'd0);
    chk("rdata_rst", mem_read_data, 32'h0);

    acc(1'b0, 1'b0, 9'h0FC, 32'h0, rd, lat);
    chk("rd_offset", rd, 32'h12345678);
    chk("lat_reg", lat, 32'd3);
    acc(1'b0, 1'b0, 9'h0FE, 32'h0, rd, lat);
    chk("rd_cmd", rd, 32'h0);
    acc(1'b0, 1'b0, 9'h0FF, 32'h0, rd, lat);
    chk("rd_ready", rd, 32'h1);
    acc(1'b1, 1'b0, 9'h010, 32'hDEADBEEF, rd, lat);
    acc(1'b0, 1'b0, 9'h010, 32'h0, rd, lat);
    chk("rd_unmapped", rd, 32'h0);
    chk("txd_idle", {31'b0, txd}, 32'd1);

    acc(1'b1, 1'b0, 9'h0FE, 32'hFFFF0003, rd, lat);
    acc(1'b0, 1'b0, 9'h0FE, 32'h0, rd, lat);
    chk("rd_cmd3", rd, 32'h3);
    acc(1'b0, 1'b0, 9'h0FF, 32'h0, rd, lat);
    chk("ready_cmd3", rd, 32'h0);
    acc(1'b1, 1'b0, 9'h0FE, 32'h0, rd, lat);

    acc(1'b1, 1'b0, 9'h100, 32'hA1B2C3D4, rd, lat);
    chk("lat_wstore", lat, 32'd7);
    acc(1'b0, 1'b1, 9'h100, 32'h0, rd, lat);
    chk("hload_100", rd, 32'hFFFFA1B2);
    chk("lat_hload", lat, 32'd5);
    acc(1'b0, 1'b1, 9'h101, 32'h0, rd, lat);
    chk("hload_101", rd, 32'hFFFFC3D4);
    acc(1'b0, 1'b0, 9'h100, 32'h0, rd, lat);
    chk("wload_100", rd, 32'hA1B2C3D4);
    chk("lat_wload", lat, 32'd7);
    acc(1'b1, 1'b1, 9'h103, 32'hEEEE1234, rd, lat);
    acc(1'b0, 1'b1, 9'h103, 32'h0, rd, lat);
    chk("hload_pos", rd, 32'h00001234);

    acc(1'b1, 1'b0, 9'h1FF, 32'h11223344, rd, lat);
    chk("lat_wrap_st", lat, 32'd5);
    acc(1'b0, 1'b0, 9'h1FF, 32'h0, rd, lat);
    chk("wrap_load", rd, 32'h11220000);
    chk("lat_wrap_ld", lat, 32'd5);
    acc(1'b0, 1'b0, 9'h100, 32'h0, rd, lat);
    chk("wrap_byte0", rd, 32'hA1B2C3D4);

    for (int j = 0; j < 128; j++)
      acc(1'b1, 1'b0, 9'(256 + 2 * j),
          {8'(4 * j), 8'(4 * j + 1), 8'(4 * j + 2), 8'(4 * j + 3)}, rd, lat);
    acc(1'b1, 1'b0, 9'h0FC, 32'h00000200, rd, lat);
    acc(1'b1, 1'b0, 9'h0FE, 32'h00000002, rd, lat);
    hdr = 40'h00_00_02_00_02;
    for (int i = 0; i < 517; i++) begin
      ex = (i < 5) ? hdr[39 - 8 * i -: 8] : 8'(i - 5);
      recv_frame(fb, fok);
      chk("wr_frame", {23'b0, fok, fb}, {23'b0, 1'b1, ex});
      if (!fok) break;
    end
    acc(1'b0, 1'b0, 9'h0FF, 32'h0, rd, lat);
    chk("ready_after_wr", rd, 32'h1);
    acc(1'b0, 1'b0, 9'h0FE, 32'h0, rd, lat);
    chk("cmd_after_wr", rd, 32'h0);

    acc(1'b1, 1'b0, 9'h0FE, 32'h00000001, rd, lat);
    hdr = 40'h00_00_02_00_01;
    for (int i = 0; i < 5; i++) begin
      recv_frame(fb, fok);
      chk("rd_hdr", {23'b0, fok, fb}, {23'b0, 1'b1, hdr[39 - 8 * i -: 8]});
    end
    for (int i = 0; i < 511; i++) send_frame(8'h5A, 1'b1);
    send_frame(8'h33, 1'b0);
    bus_req(1'b0, 1'b0, 9'h0FF, 32'h0);
    ok0 = ok_cnt;
    repeat (60) @(negedge clk);
    chk("pending_req", ok_cnt, ok0);
    fork
      send_frame(8'h5A, 1'b1);
      bus_done(400, rd2, lat2);
    join
    chk("ready_after_rd", rd2, 32'h1);
    for (int j = 0; j < 128; j++) begin
      acc(1'b0, 1'b0, 9'(256 + 2 * j), 32'h0, rd, lat);
      chk("rs_word", rd, 32'h5A5A5A5A);
    end
    acc(1'b0, 1'b0, 9'h1FF, 32'h0, rd, lat);
    chk("rs_wrap", rd, 32'h5A5A0000);

    acc(1'b1, 1'b0, 9'h0FE, 32'h00000002, rd, lat);
    recv_frame(fb, fok);
    recv_frame(fb, fok);
    chk("rst_pre_frame", {23'b0, fok, fb}, {23'b0, 1'b1, 8'h00});
    lows = 0;
    while (txd !== 1'b0 && lows < 200) begin
      @(negedge clk);
      lows++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("txd_after_rst", {31'b0, txd}, 32'd1);
    rst = 1'b0;
    acc(1'b0, 1'b0, 9'h0FC, 32'h0, rd, lat);
    chk("rst_offset", rd, 32'h12345678);
    acc(1'b0, 1'b0, 9'h0FE, 32'h0, rd, lat);
    chk("rst_cmd", rd, 32'h0);
    acc(1'b0, 1'b0, 9'h0FF, 32'h0, rd, lat);
    chk("rst_ready", rd, 32'h1);
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk("no_frames", lows, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
